// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch control states.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2,
        ST_FAULT = 2'd3
    } fetchState_e;

    // Value IR takes out of reset.
    localparam logic [31:0] IR_RESET_VALUE = 32'h0000_0000;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts cycles spent waiting for a memory response; saturates at MAX_WAIT.
module fetch_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Expired
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    // Clear has priority; the count holds once it reaches MAX_WAIT.
    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            count <= '0;
        end else if (Enable && !Expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign Expired = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word reads for PC, holds the result in a one-entry IR
// toward decode, advances the PC generator, handles redirects and timeouts.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  PC,
    input  logic               Flush,
    output logic               PC_enable,
    output logic               IMem_req,
    output logic [ADDR_W-1:0]  IMem_addr,
    input  logic               IMem_gnt,
    input  logic               IMem_rvalid,
    input  logic [INSTR_W-1:0] IMem_rdata,
    output logic [INSTR_W-1:0] IR,
    output logic [ADDR_W-1:0]  IR_PC,
    output logic               IR_valid,
    input  logic               IR_ready,
    output logic               Fetch_fault
);

    fetchState_e       state;
    fetchState_e       stateNext;
    logic [ADDR_W-1:0] reqPc;
    logic              drop;
    logic              dropNext;
    logic              irLoad;
    logic              irValidNext;
    logic              faultSet;
    logic              reqPcLoad;
    logic              fetchAdv;
    logic              timerExpired;

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear   (state != ST_WAIT),
        .Enable  (state == ST_WAIT),
        .Expired (timerExpired)
    );

    assign IMem_addr = PC;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_REQ;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, request and PC-advance decode.
    always_comb begin
        stateNext   = state;
        irLoad      = 1'b0;
        irValidNext = IR_valid;
        dropNext    = drop;
        faultSet    = 1'b0;
        reqPcLoad   = 1'b0;
        fetchAdv    = 1'b0;
        IMem_req    = ~Reset & ~Flush &
                      ((state == ST_REQ) | ((state == ST_FULL) & IR_ready));

        case (state)
            ST_REQ: begin
                irValidNext = 1'b0;
                if (IMem_req && IMem_gnt) begin
                    reqPcLoad = 1'b1;
                    dropNext  = 1'b0;
                    stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (IMem_rvalid) begin
                    if (!drop && !Flush) begin
                        irLoad      = 1'b1;
                        irValidNext = 1'b1;
                        fetchAdv    = 1'b1;
                        stateNext   = ST_FULL;
                    end else begin
                        dropNext  = 1'b0;
                        stateNext = ST_REQ;
                    end
                end else if (timerExpired) begin
                    faultSet  = 1'b1;
                    stateNext = ST_FAULT;
                end else if (Flush) begin
                    dropNext = 1'b1;
                end
            end
            ST_FULL: begin
                if (Flush) begin
                    irValidNext = 1'b0;
                    stateNext   = ST_REQ;
                end else if (IR_ready) begin
                    irValidNext = 1'b0;
                    if (IMem_gnt) begin
                        reqPcLoad = 1'b1;
                        stateNext = ST_WAIT;
                    end else begin
                        stateNext = ST_REQ;
                    end
                end
            end
            ST_FAULT: begin
                irValidNext = 1'b0;
            end
            default: begin
                stateNext = ST_REQ;
            end
        endcase

        PC_enable = ~Reset & (fetchAdv | (Flush & (state != ST_FAULT)));
    end

    // IR, its address, in-flight bookkeeping and the sticky fault flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            IR          <= INSTR_W'(IR_RESET_VALUE);
            IR_PC       <= '0;
            IR_valid    <= 1'b0;
            Fetch_fault <= 1'b0;
            drop        <= 1'b0;
            reqPc       <= '0;
        end else begin
            if (irLoad) begin
                IR    <= IMem_rdata;
                IR_PC <= reqPc;
            end
            if (reqPcLoad) begin
                reqPc <= PC;
            end
            if (faultSet) begin
                Fetch_fault <= 1'b1;
            end
            IR_valid <= irValidNext;
            drop     <= dropNext;
        end
    end

endmodule
